// File: rtl/l2_instr_issuer.sv
// l2_instr_issuer: replays a small program RAM into the lab-2 control FSM,
// raising execute per instruction and handshaking on its DONE/IDLE states.
module l2_instr_issuer #(
  parameter int AW      = 4,
  parameter int TIMEOUT = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [9:0]    prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  input  logic [3:0]    sm_state,
  output logic          execute,
  output logic [1:0]    operation,
  output logic [1:0]    regXaddr,
  output logic [1:0]    regYaddr,
  output logic [3:0]    input_data,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] pc
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO      = WW'(TIMEOUT);
  localparam logic [3:0]    SM_IDLE = 4'b0000;
  localparam logic [3:0]    SM_DONE = 4'b1000;
  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_RELEASE,
    S_FINISH,
    S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [WW-1:0] wd_q, wd_d, wd_inc;
  logic [9:0]    ir_q, ir_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          exec_q, exec_d;
  logic [AW:0]   len_eff;
  logic          len_zero;
  logic          last;
  logic          timeout;

  logic [9:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (prog_we && !busy_q) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    len_eff  = (prog_len > DEPTH) ? DEPTH : prog_len;
    len_zero = (prog_len == '0);
    last     = ({1'b0, pc_q} == len_eff - 1'b1);
    wd_inc   = wd_q + 1'b1;
    timeout  = (wd_inc == TO);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wd_d    = wd_q;
    ir_d    = ir_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = len_zero ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = mem[pc_q];
        wd_d    = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wd_d = wd_inc;
        if (timeout) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (sm_state == SM_DONE) begin
          wd_d    = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        wd_d = wd_inc;
        if (timeout) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (sm_state == SM_IDLE) begin
          if (last) begin
            state_d = S_FINISH;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort overrides everything, leaving pc where it stopped
    if (abort) begin
      state_d = S_IDLE;
      pc_d    = pc_q;
      wd_d    = wd_q;
      ir_d    = ir_q;
      busy_d  = 1'b0;
      err_d   = 1'b0;
      done_d  = 1'b0;
    end
    exec_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wd_q    <= '0;
      ir_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      exec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wd_q    <= wd_d;
      ir_q    <= ir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      exec_q  <= exec_d;
    end
  end

  assign execute    = exec_q;
  assign operation  = ir_q[9:8];
  assign regXaddr   = ir_q[7:6];
  assign regYaddr   = ir_q[5:4];
  assign input_data = ir_q[3:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_l2_instr_issuer.sv
// tb_l2_instr_issuer: directed runs against a behavioural lab-2 control FSM,
// with a scoreboard checking every issued instruction word.
module tb_l2_instr_issuer;

  localparam int AW      = 4;
  localparam int TIMEOUT = 31;

  localparam logic [9:0] I0 = 10'b00_01_00_0101;
  localparam logic [9:0] I1 = 10'b11_01_10_0000;
  localparam logic [9:0] I2 = 10'b10_01_10_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [9:0]    prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          abort;
  logic [3:0]    sm_state = 4'b0000;
  logic          execute;
  logic [1:0]    operation;
  logic [1:0]    regXaddr;
  logic [1:0]    regYaddr;
  logic [3:0]    input_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] pc;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int done_exp = 0;
  logic [9:0] exp_q[$];
  logic stuck     = 1'b0;
  logic prev_exec = 1'b0;

  l2_instr_issuer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_len   (prog_len),
    .start      (start),
    .abort      (abort),
    .sm_state   (sm_state),
    .execute    (execute),
    .operation  (operation),
    .regXaddr   (regXaddr),
    .regYaddr   (regYaddr),
    .input_data (input_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] outs();
    return {execute, operation, regXaddr, regYaddr, input_data,
            busy, done, error, pc};
  endfunction

  // Lab-2 control FSM stand-in: IDLE->1->2->4->DONE, back to IDLE once execute drops
  always @(negedge clk) begin
    if (!rst_n) begin
      sm_state = 4'b0000;
    end else begin
      case (sm_state)
        4'b0000: if (execute) sm_state = stuck ? 4'b0010 : 4'b0001;
        4'b0001: sm_state = execute ? 4'b0010 : 4'b0000;
        4'b0010: sm_state = !execute ? 4'b0000 : (stuck ? 4'b0010 : 4'b0100);
        4'b0100: sm_state = execute ? 4'b1000 : 4'b0000;
        4'b1000: if (!execute) sm_state = 4'b0000;
        default: sm_state = 4'b0000;
      endcase
    end
  end

  always begin
    logic [9:0] e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      prev_exec = 1'b0;
    end else begin
      if (execute && !prev_exec) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL issue_unexpected: got word %0h expected no issue",
                   {operation, regXaddr, regYaddr, input_data});
        end else begin
          e = exp_q.pop_front();
          check("issue_word",
                {22'd0, operation, regXaddr, regYaddr, input_data}, {22'd0, e});
        end
      end
      if (sm_state == 4'b1000 && prev_exec)
        check("exec_drop_after_done", {31'd0, execute}, 32'd0);
      if (done) done_cnt++;
      prev_exec = execute;
    end
  end

  task automatic prog(input int addr, input logic [9:0] data);
    prog_we   = 1'b1;
    prog_addr = AW'(addr);
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic go(input logic [AW:0] len);
    prog_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int  cnt;
    bit  seen;
    rst_n     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_len  = '0;
    start     = 1'b0;
    abort     = 1'b0;
    repeat (2) tick();
    check("reset_outputs", {14'd0, outs()}, 32'd0);
    rst_n = 1'b1;
    prog(0, I0);
    prog(1, I1);
    prog(2, I2);

    // three-instruction program
    exp_q.push_back(I0);
    exp_q.push_back(I1);
    exp_q.push_back(I2);
    go(5'd3);
    check("t1_busy_on_start", {31'd0, busy}, 32'd1);
    wait_done("t1_done_seen", 300);
    check("t1_busy_low_at_done", {31'd0, busy}, 32'd0);
    check("t1_pc_last", {28'd0, pc}, 32'd2);
    tick();
    done_exp++;
    check("t1_done_one_cycle", {31'd0, done}, 32'd0);
    check("t1_done_count", done_cnt, done_exp);
    check("t1_queue_empty", exp_q.size(), 0);

    // empty program
    go(5'd0);
    check("t2_busy_done_first", {30'd0, busy, done}, 32'b10);
    tick();
    check("t2_done_busy_second", {30'd0, done, busy}, 32'b10);
    tick();
    done_exp++;
    check("t2_done_count", done_cnt, done_exp);

    // FSM stuck: watchdog fires, restart clears error
    stuck = 1'b1;
    exp_q.push_back(I0);
    go(5'd1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (error) break;
      if (execute) cnt++;
    end
    check("t3_timeout_cycles", cnt, TIMEOUT);
    check("t3_err_exec_busy", {29'd0, error, execute, busy}, 32'b100);
    stuck = 1'b0;
    exp_q.push_back(I0);
    go(5'd1);
    check("t3_restart_err_busy", {30'd0, error, busy}, 32'b01);
    wait_done("t3_rerun_done", 100);
    tick();
    done_exp++;

    // abort during second instruction
    exp_q.push_back(I0);
    exp_q.push_back(I1);
    go(5'd3);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (execute && pc == 4'd1) begin
        seen = 1'b1;
        break;
      end
    end
    check("t4_reach_issue2", {31'd0, seen}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_after_abort", {26'd0, execute, busy, pc}, {26'd0, 2'b00, 4'd1});
    repeat (4) tick();
    check("t4_pc_frozen", {28'd0, pc}, 32'd1);
    check("t4_no_done", done_cnt, done_exp);
    check("t4_queue_empty", exp_q.size(), 0);

    // RAM write and start while busy are ignored
    exp_q.push_back(I0);
    go(5'd1);
    check("t5_busy", {31'd0, busy}, 32'd1);
    prog(0, 10'h3FF);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5_done", 100);
    tick();
    done_exp++;
    exp_q.push_back(I0);
    go(5'd1);
    wait_done("t5_rerun_done", 100);
    tick();
    done_exp++;
    check("t5_queue_empty", exp_q.size(), 0);

    // reset mid-RELEASE, then rerun
    exp_q.push_back(I0);
    go(5'd3);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy && !execute && sm_state == 4'b1000) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_reach_release", {31'd0, seen}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("t6_reset_outputs", {14'd0, outs()}, 32'd0);
    rst_n = 1'b1;
    check("t6_queue_empty", exp_q.size(), 0);
    exp_q.push_back(I0);
    exp_q.push_back(I1);
    exp_q.push_back(I2);
    go(5'd3);
    wait_done("t6_rerun_done", 300);
    tick();
    done_exp++;
    check("t6_rerun_queue", exp_q.size(), 0);

    // full RAM with oversize length clamps to 16 instructions
    for (int i = 0; i < 16; i++) begin
      logic [9:0] w;
      w = 10'((i * 73 + 17) % 1024);
      prog(i, w);
      exp_q.push_back(w);
    end
    go(5'd31);
    wait_done("t7_done", 800);
    check("t7_pc_last", {28'd0, pc}, 32'd15);
    tick();
    done_exp++;
    check("t7_queue_empty", exp_q.size(), 0);
    check("total_done_count", done_cnt, done_exp);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
